// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic phase scheduler.
//   state_t   : phase encodings driven onto the phase output
//   LAMP_*    : one-hot lamp patterns {red,yellow,green}
//   ROAD_*    : road identifiers used to remember which road was served last
package traffic_pkg;

  typedef enum logic [2:0] {
    A_GREEN    = 3'd0,
    A_YELLOW   = 3'd1,
    ALL_RED    = 3'd2,
    B_GREEN    = 3'd3,
    B_YELLOW   = 3'd4,
    PED_WALK   = 3'd5,
    PED_CLEAR  = 3'd6,
    PH_INVALID = 3'd7
  } state_t;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  localparam logic ROAD_A = 1'b0;
  localparam logic ROAD_B = 1'b1;

endpackage

// File: rtl/traffic_phase_scheduler_tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV cycles.
//   clk   : clock
//   reset : synchronous, active-high; restarts the count at 0
//   tick  : high for one cycle when the count is TICK_DIV-1
module tick_prescaler #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  // Decoded from the registered count, so tick carries no input path.
  assign tick = (count == LAST);

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Demand-actuated phase scheduler for a two-road intersection with a
// pedestrian crossing. Sequences green/yellow/all-red/walk/clear phases.
//   clk, reset            : clock, synchronous active-high reset
//   req_a, req_b          : vehicle detectors (level)
//   ped_btn               : pedestrian button (any-width pulse)
//   a_light, b_light      : {red,yellow,green} one-hot lamps per road
//   walk, dont_walk       : pedestrian lamps
//   ped_flash             : don't-walk flashing during pedestrian clearance
//   ped_pending           : latched pedestrian request
//   phase                 : current state encoding
//   timer                 : seconds remaining in the phase (0 while a green rests)
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int TICK_DIV       = 50000000,
  parameter int MIN_GREEN      = 10,
  parameter int MAX_GREEN      = 30,
  parameter int YELLOW_TIME    = 4,
  parameter int ALL_RED_TIME   = 2,
  parameter int WALK_TIME      = 8,
  parameter int PED_CLEAR_TIME = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_a,
  input  logic       req_b,
  input  logic       ped_btn,
  output logic [2:0] a_light,
  output logic [2:0] b_light,
  output logic       walk,
  output logic       dont_walk,
  output logic       ped_flash,
  output logic       ped_pending,
  output logic [2:0] phase,
  output logic [7:0] timer
);

  localparam logic [7:0] MIN_G = 8'(MIN_GREEN);
  localparam logic [7:0] MAX_G = 8'(MAX_GREEN);
  localparam logic [7:0] YEL_T = 8'(YELLOW_TIME);
  localparam logic [7:0] AR_T  = 8'(ALL_RED_TIME);
  localparam logic [7:0] WLK_T = 8'(WALK_TIME);
  localparam logic [7:0] CLR_T = 8'(PED_CLEAR_TIME);

  state_t     state, state_n;
  logic [7:0] timer_r, timer_n;
  logic [7:0] green_cnt, green_cnt_n;
  logic       last_road, last_road_n;
  logic       ped_pending_r, ped_pending_n;
  logic       tick;
  logic       own, conflict, green_exit;
  logic [7:0] g;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  // Own/conflicting demand for whichever green is active; g is the green
  // time that will have elapsed once the current tick is counted.
  assign own        = (state == B_GREEN) ? req_b : req_a;
  assign conflict   = ((state == B_GREEN) ? req_a : req_b) | ped_pending_r;
  assign g          = green_cnt + 8'd1;
  assign green_exit = conflict && (g >= MIN_G) && (!own || (g >= MAX_G));

  always_comb begin
    state_n       = state;
    timer_n       = timer_r;
    green_cnt_n   = green_cnt;
    last_road_n   = last_road;
    ped_pending_n = ped_pending_r | ped_btn;

    unique case (state)
      A_GREEN, B_GREEN: begin
        if (tick) begin
          if (green_exit) begin
            state_n = (state == A_GREEN) ? A_YELLOW : B_YELLOW;
            timer_n = YEL_T;
          end else begin
            timer_n     = (timer_r == 8'd0) ? 8'd0 : timer_r - 8'd1;
            green_cnt_n = (green_cnt >= MAX_G) ? MAX_G : green_cnt + 8'd1;
          end
        end
      end
      A_YELLOW, B_YELLOW: begin
        if (tick) begin
          if (timer_r <= 8'd1) begin
            state_n = ALL_RED;
            timer_n = AR_T;
          end else begin
            timer_n = timer_r - 8'd1;
          end
        end
      end
      ALL_RED: begin
        if (tick) begin
          if (timer_r > 8'd1) begin
            timer_n = timer_r - 8'd1;
          end else if (ped_pending_r) begin
            // A press on this very edge is absorbed by the walk it starts.
            state_n       = PED_WALK;
            timer_n       = WLK_T;
            ped_pending_n = 1'b0;
          end else begin
            state_n     = (last_road == ROAD_A) ? B_GREEN : A_GREEN;
            timer_n     = MIN_G;
            green_cnt_n = 8'd0;
            last_road_n = (last_road == ROAD_A) ? ROAD_B : ROAD_A;
          end
        end
      end
      PED_WALK: begin
        if (tick) begin
          if (timer_r <= 8'd1) begin
            state_n = PED_CLEAR;
            timer_n = CLR_T;
          end else begin
            timer_n = timer_r - 8'd1;
          end
        end
      end
      PED_CLEAR: begin
        if (tick) begin
          if (timer_r <= 8'd1) begin
            state_n     = (last_road == ROAD_A) ? B_GREEN : A_GREEN;
            timer_n     = MIN_G;
            green_cnt_n = 8'd0;
            last_road_n = (last_road == ROAD_A) ? ROAD_B : ROAD_A;
          end else begin
            timer_n = timer_r - 8'd1;
          end
        end
      end
      default: begin
        // Unused encoding recovers straight into a fresh A green.
        state_n     = A_GREEN;
        timer_n     = MIN_G;
        green_cnt_n = 8'd0;
        last_road_n = ROAD_A;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= A_GREEN;
      timer_r       <= MIN_G;
      green_cnt     <= 8'd0;
      last_road     <= ROAD_A;
      ped_pending_r <= 1'b0;
    end else begin
      state         <= state_n;
      timer_r       <= timer_n;
      green_cnt     <= green_cnt_n;
      last_road     <= last_road_n;
      ped_pending_r <= ped_pending_n;
    end
  end

  // Lamps decode from the registered state only.
  always_comb begin
    a_light   = LAMP_RED;
    b_light   = LAMP_RED;
    walk      = 1'b0;
    ped_flash = 1'b0;
    unique case (state)
      A_GREEN:   a_light = LAMP_GRN;
      A_YELLOW:  a_light = LAMP_YEL;
      B_GREEN:   b_light = LAMP_GRN;
      B_YELLOW:  b_light = LAMP_YEL;
      PED_WALK:  walk = 1'b1;
      PED_CLEAR: ped_flash = 1'b1;
      default:   ;
    endcase
  end

  assign dont_walk   = ~walk;
  assign ped_pending = ped_pending_r;
  assign phase       = state;
  assign timer       = timer_r;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
module tb_traffic_phase_scheduler;

  localparam int TDIV = 2;
  localparam int MING = 3;
  localparam int MAXG = 6;
  localparam int YEL  = 2;
  localparam int AR   = 1;
  localparam int WLK  = 3;
  localparam int CLR  = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_a = 1'b0, req_b = 1'b0, ped_btn = 1'b0;
  logic [2:0] a_light, b_light, phase;
  logic       walk, dont_walk, ped_flash, ped_pending;
  logic [7:0] timer;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  traffic_phase_scheduler #(
    .TICK_DIV(TDIV), .MIN_GREEN(MING), .MAX_GREEN(MAXG), .YELLOW_TIME(YEL),
    .ALL_RED_TIME(AR), .WALK_TIME(WLK), .PED_CLEAR_TIME(CLR)
  ) dut (
    .clk(clk), .reset(reset), .req_a(req_a), .req_b(req_b), .ped_btn(ped_btn),
    .a_light(a_light), .b_light(b_light), .walk(walk), .dont_walk(dont_walk),
    .ped_flash(ped_flash), .ped_pending(ped_pending), .phase(phase), .timer(timer)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks phase, ticks elapsed in the phase, last road served and the
  // pedestrian latch; outputs follow from these by the phase rules.
  int m_phase = 0, m_el = 0, m_last = 0, m_ped = 0, m_div = 0;
  bit m_valid = 0;

  function automatic int dur(input int p);
    case (p)
      1, 4:    return YEL;
      2:       return AR;
      5:       return WLK;
      6:       return CLR;
      default: return 0;
    endcase
  endfunction

  function automatic int exp_timer(input int p, input int el);
    if (p == 0 || p == 3) return (MING - el > 0) ? MING - el : 0;
    return dur(p) - el;
  endfunction

  function automatic int exp_a(input int p);
    case (p)
      0:       return 1;
      1:       return 2;
      default: return 4;
    endcase
  endfunction

  function automatic int exp_b(input int p);
    case (p)
      3:       return 1;
      4:       return 2;
      default: return 4;
    endcase
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        m_phase = 0; m_el = 0; m_last = 0; m_ped = 0; m_div = 0; m_valid = 1;
      end else if (m_valid) begin
        bit tk, into_walk;
        int nxt;
        tk = (m_div == TDIV - 1);
        m_div = tk ? 0 : m_div + 1;
        into_walk = 0;
        nxt = m_phase;
        if (tk) begin
          if (m_phase == 0 || m_phase == 3) begin
            bit own, conf;
            own  = (m_phase == 0) ? req_a : req_b;
            conf = ((m_phase == 0) ? req_b : req_a) || (m_ped != 0);
            if (conf && m_el + 1 >= MING && (!own || m_el + 1 >= MAXG)) nxt = m_phase + 1;
          end else if (m_el + 1 == dur(m_phase)) begin
            case (m_phase)
              1, 4: nxt = 2;
              2:    nxt = (m_ped != 0) ? 5 : ((m_last == 0) ? 3 : 0);
              5:    nxt = 6;
              default: nxt = (m_last == 0) ? 3 : 0;
            endcase
          end
          if (nxt != m_phase) begin
            m_el = 0;
            if (nxt == 0) m_last = 0;
            if (nxt == 3) m_last = 1;
            if (nxt == 5) into_walk = 1;
            m_phase = nxt;
          end else begin
            m_el++;
          end
        end
        m_ped = into_walk ? 0 : (m_ped | int'(ped_btn));
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        chk("phase", int'(phase), m_phase);
        chk("timer", int'(timer), exp_timer(m_phase, m_el));
        chk("a_light", int'(a_light), exp_a(m_phase));
        chk("b_light", int'(b_light), exp_b(m_phase));
        chk("walk", int'(walk), (m_phase == 5) ? 1 : 0);
        chk("dont_walk", int'(dont_walk), (m_phase == 5) ? 0 : 1);
        chk("ped_flash", int'(ped_flash), (m_phase == 6) ? 1 : 0);
        chk("ped_pending", int'(ped_pending), m_ped);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
    cyc += n;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic wait_phase(input int target, input int limit);
    int n = 0;
    while (int'(phase) != target && n < limit) begin
      step(1);
      n++;
    end
    checks++;
    if (int'(phase) != target) begin
      errors++;
      $display("FAIL wait_phase: phase=%0d, required %0d within %0d cycles", phase, target, limit);
    end
  endtask

  initial begin
    // 1: idle from reset, green rests with timer 0
    do_reset();
    chk("rst_phase", int'(phase), 0);
    chk("rst_timer", int'(timer), 3);
    chk("rst_a", int'(a_light), 1);
    chk("rst_b", int'(b_light), 4);
    chk("rst_dont_walk", int'(dont_walk), 1);
    step(8);
    chk("s1_timer0", int'(timer), 0);
    step(100);
    chk("s1_rest_phase", int'(phase), 0);
    chk("s1_rest_timer", int'(timer), 0);

    // 2: road B demand only
    req_b = 1'b1;
    do_reset();
    wait_phase(3, 40);
    chk("s2_bgreen_cyc", cyc, 12);
    chk("s2_a", int'(a_light), 4);
    chk("s2_b", int'(b_light), 1);
    chk("s2_timer", int'(timer), 3);

    // 3: both roads demand, A held to max green
    req_a = 1'b1;
    do_reset();
    wait_phase(1, 40);
    chk("s3_ayel_cyc", cyc, 12);

    // 4: pedestrian press on the first tick of A green
    req_a = 1'b0; req_b = 1'b0;
    do_reset();
    step(1); ped_btn = 1'b1;
    step(1); ped_btn = 1'b0;
    chk("s4_pending", int'(ped_pending), 1);
    wait_phase(1, 40);
    chk("s4_ayel_cyc", cyc, 6);
    wait_phase(5, 40);
    chk("s4_walk_cyc", cyc, 12);
    chk("s4_walk", int'(walk), 1);
    chk("s4_walk_timer", int'(timer), 3);
    chk("s4_pending_clr", int'(ped_pending), 0);
    wait_phase(6, 40);
    chk("s4_flash", int'(ped_flash), 1);
    chk("s4_clr_cyc", cyc, 18);
    wait_phase(3, 40);
    chk("s4_bgreen_cyc", cyc, 22);

    // 5: press held on the edge that enters PED_WALK is absorbed
    do_reset();
    step(1); ped_btn = 1'b1;
    step(1); ped_btn = 1'b0;
    wait_phase(2, 40);
    step(1); ped_btn = 1'b1;
    step(1); ped_btn = 1'b0;
    chk("s5_walk", int'(phase), 5);
    chk("s5_pending_clr", int'(ped_pending), 0);
    wait_phase(3, 40);
    req_a = 1'b1;
    wait_phase(2, 40);
    for (int n = 0; n < 10 && int'(phase) == 2; n++) step(1);
    chk("s5_next_green", int'(phase), 0);

    // 6: reset on a tick edge during B yellow
    req_a = 1'b0; req_b = 1'b1;
    do_reset();
    wait_phase(3, 40);
    req_a = 1'b1; req_b = 1'b0;
    step(2); ped_btn = 1'b1;
    step(1); ped_btn = 1'b0;
    wait_phase(4, 40);
    chk("s6_byel_cyc", cyc, 18);
    step(1); reset = 1'b1;
    step(1); reset = 1'b0;
    chk("s6_phase", int'(phase), 0);
    chk("s6_timer", int'(timer), 3);
    chk("s6_a", int'(a_light), 1);
    chk("s6_pending", int'(ped_pending), 0);
    step(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d, required completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
